isa_dispatch: RTL and testbench

ISA_DISPATCH -- requirements
Module: isa_dispatch

---
 rtl/isa_dispatch_pkg.sv | 25 ++
 rtl/isa_dispatch_if.sv | 24 ++
 rtl/isa_decode.sv | 39 +++
 rtl/isa_dispatch.sv | 112 +++++++++++
 tb/tb_isa_dispatch.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_dispatch_pkg.sv
// Shared definitions for the ISA dispatcher: opcode map, instruction field positions, FSM encoding.
// Instruction header sits in the top five bits of a 64-bit word.
package isa_dispatch_pkg;

  localparam int OP_HI    = 63;
  localparam int OP_LO    = 60;
  localparam int SYNC_BIT = 59;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_U0  = 4'h1;
  localparam logic [3:0] OP_U1  = 4'h2;
  localparam logic [3:0] OP_U2  = 4'h3;
  localparam logic [3:0] OP_U3  = 4'h4;
  localparam logic [3:0] OP_END = 4'hF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_DATA = 3'd2,
    ISSUE     = 3'd3,
    SYNC_WAIT = 3'd4,
    DRAIN     = 3'd5
  } state_t;

endpackage

// File: rtl/isa_dispatch_if.sv
// FIFO read port and execution-unit issue bus of the dispatcher.
// master = dispatcher side, slave = FIFO/units side.
interface isa_dispatch_if #(
  parameter int DW        = 64,
  parameter int NUM_UNITS = 4
);
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic [DW-1:0]        fifo_dout;
  logic [NUM_UNITS-1:0] unit_valid;
  logic [DW-1:0]        unit_instr;
  logic [NUM_UNITS-1:0] unit_ready;
  logic [NUM_UNITS-1:0] unit_done;

  modport master (
    input  fifo_empty, fifo_dout, unit_ready, unit_done,
    output fifo_rd_en, unit_valid, unit_instr
  );

  modport slave (
    output fifo_empty, fifo_dout, unit_ready, unit_done,
    input  fifo_rd_en, unit_valid, unit_instr
  );
endinterface

// File: rtl/isa_decode.sv
// Combinational opcode decoder: target unit one-hot, NOP/END/illegal class and SYNC flag.
// Zero latency; opcodes 1..NUM_UNITS select units 0..NUM_UNITS-1.
module isa_decode
  import isa_dispatch_pkg::*;
#(
  parameter int DW        = 64,
  parameter int NUM_UNITS = 4
) (
  input  logic [DW-1:0]        i_instr,
  output logic [NUM_UNITS-1:0] o_unit_oh,
  output logic                 o_is_nop,
  output logic                 o_is_end,
  output logic                 o_is_illegal,
  output logic                 o_sync
);

  logic [3:0] w_op;
  logic       w_hit;
  logic       w_unused_bits;

  assign w_op          = i_instr[OP_HI:OP_LO];
  assign o_sync        = i_instr[SYNC_BIT];
  assign w_unused_bits = ^i_instr[SYNC_BIT-1:0];

  always_comb begin
    o_unit_oh = '0;
    w_hit     = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (int'(w_op) == int'(OP_U0) + u) begin
        o_unit_oh[u] = 1'b1;
        w_hit        = 1'b1;
      end
    end
    o_is_nop     = (w_op == OP_NOP);
    o_is_end     = (w_op == OP_END);
    o_is_illegal = !(o_is_nop || o_is_end || w_hit);
  end

endmodule

// File: rtl/isa_dispatch.sv
// Fetches instruction words from the ISA FIFO and issues them one at a time to execution units.
// Fetch-to-issue is 2 cycles; issue holds until the target unit is idle and ready, SYNC words wait for done.
module isa_dispatch
  import isa_dispatch_pkg::*;
#(
  parameter int DW        = 64,
  parameter int NUM_UNITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  isa_dispatch_if.master       bus,
  output logic                 busy,
  output logic                 err_illegal,
  output logic [15:0]          instr_count
);

  state_t               r_state;
  logic [DW-1:0]        r_instr;
  logic [NUM_UNITS-1:0] r_unit_oh;
  logic                 r_sync;
  logic [NUM_UNITS-1:0] r_pending;
  logic [15:0]          r_count;
  logic                 r_err;

  logic [NUM_UNITS-1:0] w_unit_oh;
  logic                 w_is_nop;
  logic                 w_is_end;
  logic                 w_is_illegal;
  logic                 w_sync;
  logic [NUM_UNITS-1:0] w_issue;
  logic                 w_hs;

  // FIFO data is valid during WAIT_DATA, so decode it directly and branch in that cycle.
  isa_decode #(
    .DW        (DW),
    .NUM_UNITS (NUM_UNITS)
  ) u_decode (
    .i_instr      (bus.fifo_dout),
    .o_unit_oh    (w_unit_oh),
    .o_is_nop     (w_is_nop),
    .o_is_end     (w_is_end),
    .o_is_illegal (w_is_illegal),
    .o_sync       (w_sync)
  );

  assign bus.fifo_rd_en = (r_state == FETCH) && !bus.fifo_empty;
  assign bus.unit_valid = (r_state == ISSUE) ? (r_unit_oh & ~r_pending) : '0;
  assign bus.unit_instr = r_instr;
  assign w_issue        = bus.unit_valid & bus.unit_ready;
  assign w_hs           = |w_issue;

  assign busy        = (r_state != IDLE);
  assign err_illegal = r_err;
  assign instr_count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_instr   <= '0;
      r_unit_oh <= '0;
      r_sync    <= 1'b0;
      r_pending <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      // Issue wins over a coincident done to the same unit.
      r_pending <= (r_pending & ~bus.unit_done) | w_issue;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= FETCH;
            r_count <= '0;
            r_err   <= 1'b0;
          end
        end
        FETCH: begin
          if (!bus.fifo_empty) r_state <= WAIT_DATA;
        end
        WAIT_DATA: begin
          r_instr   <= bus.fifo_dout;
          r_unit_oh <= w_unit_oh;
          r_sync    <= w_sync;
          if (w_is_end) begin
            r_state <= DRAIN;
          end else if (w_is_nop) begin
            r_state <= FETCH;
          end else if (w_is_illegal) begin
            r_err   <= 1'b1;
            r_state <= FETCH;
          end else begin
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_hs) begin
            r_count <= r_count + 16'd1;
            r_state <= r_sync ? SYNC_WAIT : FETCH;
          end
        end
        SYNC_WAIT: begin
          if ((r_pending & r_unit_oh) == '0) r_state <= FETCH;
        end
        DRAIN: begin
          if (r_pending == '0) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isa_dispatch.sv
// Directed bench for isa_dispatch: single-instruction vector table plus multi-cycle corner sequences.
module tb_isa_dispatch;
  import isa_dispatch_pkg::*;

  localparam logic [63:0] END_W = 64'hF000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        err_illegal;
  logic [15:0] instr_count;

  isa_dispatch_if #(.DW(64), .NUM_UNITS(4)) ifc ();

  isa_dispatch #(.DW(64), .NUM_UNITS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (ifc),
    .busy        (busy),
    .err_illegal (err_illegal),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // FIFO model: words pushed by the stimulus, popped on rd_en, data valid one cycle later.
  logic [63:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [63:0] dout_q = 64'd0;

  assign ifc.fifo_empty = (wr_ptr == rd_ptr);
  assign ifc.fifo_dout  = dout_q;

  always @(posedge clk) begin
    if (ifc.fifo_rd_en && (wr_ptr != rd_ptr)) begin
      dout_q <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Unit model: ready driven directly, done either auto (one cycle after accept) or manual.
  logic [3:0] ready_drv = 4'hF;
  logic [3:0] man_done  = 4'h0;
  logic [3:0] auto_q    = 4'h0;
  bit         auto_en   = 1'b1;

  assign ifc.unit_ready = ready_drv;
  assign ifc.unit_done  = auto_en ? auto_q : man_done;

  always @(posedge clk) auto_q <= ifc.unit_valid & ifc.unit_ready;

  int onehot_err  = 0;
  int overlap_err = 0;
  always @(negedge clk) begin
    if ($countones(ifc.unit_valid) > 1) onehot_err++;
    if ((ifc.unit_valid != 4'h0) && ifc.fifo_rd_en) overlap_err++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input logic [3:0] mask, input string nm);
    int c = 0;
    while (((ifc.unit_valid & mask) == 4'h0) && (c < 50)) begin
      @(negedge clk);
      c++;
    end
    chk(nm, 64'((ifc.unit_valid & mask) != 4'h0), 64'd1);
  endtask

  task automatic wait_rd(input string nm);
    int c = 0;
    while (!ifc.fifo_rd_en && (c < 50)) begin
      @(negedge clk);
      c++;
    end
    chk(nm, 64'(ifc.fifo_rd_en), 64'd1);
  endtask

  task automatic wait_idle(input string nm);
    int c = 0;
    while (busy && (c < 60)) begin
      @(negedge clk);
      c++;
    end
    chk(nm, 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [63:0] word;
    logic [3:0]  exp_valid;
    int          exp_vcyc;
    logic [15:0] exp_cnt;
    logic        exp_err;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [3:0]  seen;
    logic [63:0] seen_instr;
    int          vcyc;
    int          nrd;
    int          nv;
    int          held;
    bit          rdy_set;
    bit          err_seen;
    bit          err_drop;

    vt[0] = '{64'h1000_0000_0000_00AA, 4'b0001, 1, 16'd1, 1'b0};
    vt[1] = '{64'h2000_0000_0000_0001, 4'b0010, 1, 16'd1, 1'b0};
    vt[2] = '{64'h3000_0000_0000_0002, 4'b0100, 1, 16'd1, 1'b0};
    vt[3] = '{64'h4000_0000_0000_0003, 4'b1000, 1, 16'd1, 1'b0};
    vt[4] = '{64'h0000_0000_0000_0004, 4'b0000, 0, 16'd0, 1'b0};
    vt[5] = '{64'h7000_0000_0000_0005, 4'b0000, 0, 16'd0, 1'b1};
    vt[6] = '{64'h5000_0000_0000_0006, 4'b0000, 0, 16'd0, 1'b1};
    vt[7] = '{64'h3800_0000_0000_0011, 4'b0100, 1, 16'd1, 1'b0};

    // Reset state, then start against an empty FIFO.
    do_reset();
    chk("rst_rd_en", 64'(ifc.fifo_rd_en), 64'd0);
    chk("rst_valid", 64'(ifc.unit_valid), 64'd0);
    chk("rst_instr", ifc.unit_instr, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_illegal), 64'd0);
    chk("rst_count", 64'(instr_count), 64'd0);
    pulse_start();
    nrd = 0;
    repeat (10) begin
      if (ifc.fifo_rd_en) nrd++;
      @(negedge clk);
    end
    chk("empty_rd_en_cycles", 64'(nrd), 64'd0);
    chk("empty_busy", 64'(busy), 64'd1);
    chk("empty_state", 64'(dut.r_state), 64'(FETCH));
    push(END_W);
    #1;
    chk("empty_then_push_rd_en", 64'(ifc.fifo_rd_en), 64'd1);
    wait_idle("empty_end_idle");

    // Single-instruction programs from the table.
    for (int k = 0; k < 8; k++) begin
      do_reset();
      auto_en   = 1'b1;
      ready_drv = 4'hF;
      push(vt[k].word);
      push(END_W);
      pulse_start();
      seen = 4'h0;
      seen_instr = 64'd0;
      vcyc = 0;
      for (int c = 0; c < 40; c++) begin
        if (ifc.unit_valid != 4'h0) begin
          seen |= ifc.unit_valid;
          seen_instr = ifc.unit_instr;
          vcyc++;
        end
        if (!busy) break;
        @(negedge clk);
      end
      chk($sformatf("vec%0d_idle", k), 64'(busy), 64'd0);
      chk($sformatf("vec%0d_valid", k), 64'(seen), 64'(vt[k].exp_valid));
      chk($sformatf("vec%0d_vcyc", k), 64'(vcyc), 64'(vt[k].exp_vcyc));
      chk($sformatf("vec%0d_count", k), 64'(instr_count), 64'(vt[k].exp_cnt));
      chk($sformatf("vec%0d_err", k), 64'(err_illegal), 64'(vt[k].exp_err));
      if (vt[k].exp_vcyc != 0) chk($sformatf("vec%0d_instr", k), seen_instr, vt[k].word);
    end

    // Backpressure: unit 1 not ready for 5 cycles.
    do_reset();
    auto_en   = 1'b1;
    ready_drv = 4'h0;
    push(64'h2000_0000_0000_0BEE);
    push(END_W);
    pulse_start();
    wait_valid(4'b0010, "bp_first_valid");
    held = 0;
    rdy_set = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if ((ifc.unit_valid == 4'b0010) && (ifc.unit_instr == 64'h2000_0000_0000_0BEE)) held++;
      if ((held == 6) && !rdy_set) begin
        chk("bp_count_before", 64'(instr_count), 64'd0);
        ready_drv = 4'b0010;
        rdy_set = 1'b1;
      end
      @(negedge clk);
    end
    chk("bp_held_cycles", 64'(held), 64'd6);
    chk("bp_count_after", 64'(instr_count), 64'd1);
    wait_idle("bp_idle");
    ready_drv = 4'hF;

    // SYNC: no further fetch until unit 2 reports done.
    do_reset();
    auto_en  = 1'b0;
    man_done = 4'h0;
    push(64'h3800_0000_0000_0001);
    push(64'h3000_0000_0000_0002);
    push(END_W);
    pulse_start();
    wait_valid(4'b0100, "sync_first_valid");
    chk("sync_first_instr", ifc.unit_instr, 64'h3800_0000_0000_0001);
    @(negedge clk);
    nrd = 0;
    repeat (8) begin
      if (ifc.fifo_rd_en) nrd++;
      @(negedge clk);
    end
    chk("sync_no_fetch", 64'(nrd), 64'd0);
    chk("sync_state", 64'(dut.r_state), 64'(SYNC_WAIT));
    chk("sync_count", 64'(instr_count), 64'd1);
    man_done = 4'b0100;
    @(negedge clk);
    man_done = 4'h0;
    wait_rd("sync_fetch_after_done");
    wait_valid(4'b0100, "sync_second_valid");
    chk("sync_second_instr", ifc.unit_instr, 64'h3000_0000_0000_0002);
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("sync_drain_wait", 64'(dut.r_state), 64'(DRAIN));
    man_done = 4'b0100;
    @(negedge clk);
    man_done = 4'h0;
    wait_idle("sync_idle");
    chk("sync_final_count", 64'(instr_count), 64'd2);

    // Non-SYNC issue to a still-pending unit stalls; done coincident with issue keeps pending.
    do_reset();
    push(64'h3000_0000_0000_0003);
    push(64'h3000_0000_0000_0004);
    push(END_W);
    pulse_start();
    wait_valid(4'b0100, "stall_first_valid");
    @(negedge clk);
    nv = 0;
    repeat (6) begin
      if (ifc.unit_valid != 4'h0) nv++;
      @(negedge clk);
    end
    chk("stall_no_valid", 64'(nv), 64'd0);
    chk("stall_state", 64'(dut.r_state), 64'(ISSUE));
    chk("stall_count", 64'(instr_count), 64'd1);
    man_done = 4'b0100;
    @(negedge clk);
    man_done = 4'h0;
    wait_valid(4'b0100, "stall_release_valid");
    chk("stall_second_instr", ifc.unit_instr, 64'h3000_0000_0000_0004);
    man_done = 4'b0100;
    @(negedge clk);
    man_done = 4'h0;
    repeat (4) @(negedge clk);
    chk("done_with_issue_still_busy", 64'(busy), 64'd1);
    man_done = 4'b0100;
    @(negedge clk);
    man_done = 4'h0;
    wait_idle("stall_idle");
    chk("stall_final_count", 64'(instr_count), 64'd2);
    auto_en = 1'b1;

    // Illegal, NOP, then unit 3.
    do_reset();
    push(64'h7000_0000_0000_0000);
    push(64'h0000_0000_0000_0000);
    push(64'h4000_0000_0000_00CC);
    push(END_W);
    pulse_start();
    seen = 4'h0;
    err_seen = 1'b0;
    err_drop = 1'b0;
    for (int c = 0; c < 40; c++) begin
      seen |= ifc.unit_valid;
      if (err_illegal) err_seen = 1'b1;
      else if (err_seen) err_drop = 1'b1;
      if (!busy) break;
      @(negedge clk);
    end
    chk("ill_idle", 64'(busy), 64'd0);
    chk("ill_err", 64'(err_illegal), 64'd1);
    chk("ill_err_sticky", 64'(err_drop), 64'd0);
    chk("ill_count", 64'(instr_count), 64'd1);
    chk("ill_valid", 64'(seen), 64'b1000);
    push(END_W);
    pulse_start();
    chk("restart_err_clear", 64'(err_illegal), 64'd0);
    chk("restart_count_clear", 64'(instr_count), 64'd0);
    wait_idle("restart_idle");

    // Reset in the middle of a stalled issue.
    do_reset();
    ready_drv = 4'b1110;
    push(64'h7000_0000_0000_0000);
    push(64'h2000_0000_0000_0001);
    push(64'h1000_0000_0000_0055);
    push(END_W);
    pulse_start();
    wait_valid(4'b0001, "mid_valid");
    chk("mid_pre_err", 64'(err_illegal), 64'd1);
    chk("mid_pre_count", 64'(instr_count), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rd_en", 64'(ifc.fifo_rd_en), 64'd0);
    chk("mid_valid_clear", 64'(ifc.unit_valid), 64'd0);
    chk("mid_instr", ifc.unit_instr, 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_err", 64'(err_illegal), 64'd0);
    chk("mid_count", 64'(instr_count), 64'd0);
    chk("mid_pending", 64'(dut.r_pending), 64'd0);
    reset = 1'b0;
    nrd = 0;
    nv = 0;
    repeat (4) begin
      @(negedge clk);
      if (ifc.fifo_rd_en) nrd++;
      if (ifc.unit_valid != 4'h0) nv++;
    end
    chk("mid_after_no_read", 64'(nrd), 64'd0);
    chk("mid_after_no_issue", 64'(nv), 64'd0);

    chk("valid_onehot", 64'(onehot_err), 64'd0);
    chk("valid_vs_rd_en", 64'(overlap_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
